// File: rtl/shape_processor_cmd_queue.sv
// shape_processor_cmd_queue: buffers SFR commands in a FIFO and sequences one shape_processor access at a time.
// Optional SHAPE_CMDQ_ERR_FLUSH_EN: an access that reports error discards every queued command.
module shape_processor_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_read,
    input  logic [31:0]             cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic                    rsp_error,
    output logic                    write,
    output logic [31:0]             write_data,
    output logic                    read,
    input  logic [31:0]             read_data,
    input  logic                    error,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, RESP} state_t;

    state_t        state_q, state_d;
    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          cur_is_read_q;
    logic [31:0]   write_data_q, rsp_data_q;
    logic          rsp_error_q;
    logic          push, pop, flush, empty;
    logic [32:0]   head;

    assign empty = count_q == '0;
    assign head  = mem_q[rd_ptr_q];

`ifdef SHAPE_CMDQ_ERR_FLUSH_EN
    assign cmd_ready = (count_q != FULL_CNT) && (state_q != SAMPLE);
    assign flush     = (state_q == SAMPLE) && error;
`else
    assign cmd_ready = count_q != FULL_CNT;
    assign flush     = 1'b0;
`endif

    assign push = cmd_valid && cmd_ready;
    assign pop  = !empty && (state_q == IDLE || (state_q == RESP && rsp_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= flush ? wr_ptr_q : rd_ptr_q + AW'(pop);
            count_q  <= flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: entries are only read once counted as occupied.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_is_read, cmd_data};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   state_d = empty ? IDLE : ISSUE;
            ISSUE:  state_d = SAMPLE;
            SAMPLE: state_d = RESP;
            RESP:   state_d = !rsp_ready ? RESP : (empty ? IDLE : ISSUE);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_is_read_q <= 1'b0;
            write_data_q  <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cur_is_read_q <= head[32];
                if (!head[32]) write_data_q <= head[31:0];
            end
            if (state_q == SAMPLE) begin
                rsp_data_q  <= cur_is_read_q ? read_data : '0;
                rsp_error_q <= error;
            end
        end
    end

    assign write      = (state_q == ISSUE) && !cur_is_read_q;
    assign read       = (state_q == ISSUE) && cur_is_read_q;
    assign write_data = write_data_q;
    assign rsp_valid  = state_q == RESP;
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;
    assign level      = count_q;

endmodule
